// File: rtl/wb_mac_pkg.sv
// Shared definitions for the Wishbone MAC register block: register word offsets,
// CTRL/STATUS bit positions, bus/compute state encodings and a byte-lane merge helper.
package wb_mac_pkg;

   localparam logic [2:0] OFF_CTRL    = 3'd0;
   localparam logic [2:0] OFF_OPERAND = 3'd1;
   localparam logic [2:0] OFF_ADDEND  = 3'd2;
   localparam logic [2:0] OFF_RESULT  = 3'd3;
   localparam logic [2:0] OFF_STATUS  = 3'd4;

   localparam int CTRL_START    = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_CLR_DONE = 2;
   localparam int CTRL_ACC      = 3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_ERR  = 2;

   typedef enum logic {B_IDLE, B_ACK} bus_state_e;
   typedef enum logic {C_IDLE, C_RUN} comp_state_e;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] merged;
      merged = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_val[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/wb_mac_seq.sv
// Compute sequencer for the MAC register block: start/run FSM, latency counter,
// and capture of the MAC result together with the sticky DONE and ERR flags.
module wb_mac_seq
   import wb_mac_pkg::*;
#(
   parameter int MAC_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        clr_i,
   input  logic        err_set_i,
   input  logic        acc_en_i,
   input  logic [31:0] mac_res_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        acc_load_o,
   output logic [31:0] result_o
);

   // Counting down to zero from LATENCY-1 keeps BUSY high for exactly MAC_LATENCY cycles.
   localparam logic [3:0] CNT_LOAD = 4'(MAC_LATENCY - 1);

   comp_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] result_q, result_d;
   logic        capture;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      err_d    = err_q;
      result_d = result_q;
      capture  = 1'b0;

      if (clr_i) begin
         done_d = 1'b0;
         err_d  = 1'b0;
      end

      case (state_q)
         C_IDLE: begin
            if (start_i) begin
               state_d = C_RUN;
               cnt_d   = CNT_LOAD;
               done_d  = 1'b0;
            end
         end
         C_RUN: begin
            if (cnt_q == 4'd0) begin
               capture  = 1'b1;
               result_d = mac_res_i;
               done_d   = 1'b1;
               state_d  = C_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = C_IDLE;
      endcase

      // A rejected access during a run is flagged even if the same write also clears.
      if (err_set_i) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= C_IDLE;
         cnt_q    <= 4'd0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         result_q <= result_d;
      end
   end

   assign busy_o     = (state_q == C_RUN);
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign result_o   = result_q;
   assign acc_load_o = capture & acc_en_i;

endmodule

// File: rtl/wb_mac_regs.sv
// Wishbone B4 classic register window in front of the MAC core (one wait state per access).
// Define WB_MAC_ACCUM_EN to add CTRL.ACC, which feeds each captured result back into ADDEND.
module wb_mac_regs
   import wb_mac_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          MAC_LATENCY = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [15:0] mac_mx_o,
   output logic [15:0] mac_my_o,
   output logic [31:0] mac_az_o,
   input  logic [31:0] mac_res_i,
   output logic        irq_o
);

   bus_state_e  bus_state_q, bus_state_d;
   logic        in_window, bus_req, ack, wr;
   logic        wr_ctrl, wr_operand, wr_addend;
   logic        start_req, clr_req, err_set;
   logic [2:0]  reg_off;
   logic [31:0] operand_q, operand_d;
   logic [31:0] addend_q, addend_d;
   logic        irq_en_q, irq_en_d;
   logic        irq_q, irq_d;
   logic        acc, busy, done, err, acc_load;
   logic [31:0] result, rdata;
   logic        unused_adr_lsb;

   assign unused_adr_lsb = ^wbs_adr_i[1:0];

   assign in_window = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
   assign bus_req   = wbs_cyc_i & wbs_stb_i;
   assign reg_off   = wbs_adr_i[4:2];
   assign ack       = (bus_state_q == B_ACK);
   assign wr        = ack & bus_req & wbs_we_i;

   assign wr_ctrl    = wr & (reg_off == OFF_CTRL) & wbs_sel_i[0];
   assign wr_operand = wr & (reg_off == OFF_OPERAND);
   assign wr_addend  = wr & (reg_off == OFF_ADDEND);
   assign start_req  = wr_ctrl & wbs_dat_i[CTRL_START];
   assign clr_req    = wr_ctrl & wbs_dat_i[CTRL_CLR_DONE];
   assign err_set    = busy & (start_req | wr_operand | wr_addend);

   always_comb begin
      bus_state_d = bus_state_q;
      case (bus_state_q)
         B_IDLE:  if (bus_req && in_window) bus_state_d = B_ACK;
         B_ACK:   bus_state_d = B_IDLE;
         default: bus_state_d = B_IDLE;
      endcase
   end

   // Operand/addend writes are dropped while a computation is in flight.
   always_comb begin
      operand_d = operand_q;
      addend_d  = addend_q;
      irq_en_d  = irq_en_q;
      irq_d     = done & irq_en_q;
      if (wr_ctrl) irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
      if (wr_operand && !busy) operand_d = byte_merge(operand_q, wbs_dat_i, wbs_sel_i);
      if (acc_load) begin
         addend_d = mac_res_i;
      end else if (wr_addend && !busy) begin
         addend_d = byte_merge(addend_q, wbs_dat_i, wbs_sel_i);
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         bus_state_q <= B_IDLE;
         operand_q   <= 32'd0;
         addend_q    <= 32'd0;
         irq_en_q    <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         bus_state_q <= bus_state_d;
         operand_q   <= operand_d;
         addend_q    <= addend_d;
         irq_en_q    <= irq_en_d;
         irq_q       <= irq_d;
      end
   end

`ifdef WB_MAC_ACCUM_EN
   logic acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (wr_ctrl) acc_d = wbs_dat_i[CTRL_ACC];
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) acc_q <= 1'b0;
      else          acc_q <= acc_d;
   end

   assign acc = acc_q;
`else
   assign acc = 1'b0;
`endif

   wb_mac_seq #(
      .MAC_LATENCY (MAC_LATENCY)
   ) u_seq (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .start_i    (start_req),
      .clr_i      (clr_req),
      .err_set_i  (err_set),
      .acc_en_i   (acc),
      .mac_res_i  (mac_res_i),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .acc_load_o (acc_load),
      .result_o   (result)
   );

   always_comb begin
      rdata = 32'd0;
      case (reg_off)
         OFF_CTRL: begin
            rdata[CTRL_IRQ_EN] = irq_en_q;
            rdata[CTRL_ACC]    = acc;
         end
         OFF_OPERAND: rdata = operand_q;
         OFF_ADDEND:  rdata = addend_q;
         OFF_RESULT:  rdata = result;
         OFF_STATUS: begin
            rdata[STAT_BUSY] = busy;
            rdata[STAT_DONE] = done;
            rdata[STAT_ERR]  = err;
         end
         default: rdata = 32'd0;
      endcase
   end

   assign wbs_ack_o = ack;
   assign wbs_dat_o = (ack && !wbs_we_i) ? rdata : 32'd0;
   assign mac_mx_o  = operand_q[15:0];
   assign mac_my_o  = operand_q[31:16];
   assign mac_az_o  = addend_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_mac_regs.sv
// Scoreboard bench for wb_mac_regs: bus reads queue their expected data from a
// cycle-based reference model; a negedge monitor pops and compares on every read ack.
`timescale 1ns/1ps
module tb_wb_mac_regs;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          LAT  = 2;

   logic        wb_clk_i  = 1'b0;
   logic        wb_rst_i  = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_we_i  = 1'b0;
   logic [3:0]  wbs_sel_i = 4'h0;
   logic [31:0] wbs_dat_i = 32'd0;
   logic [31:0] wbs_adr_i = 32'd0;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic [15:0] mac_mx_o, mac_my_o;
   logic [31:0] mac_az_o, mac_res_i;
   logic        irq_o;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } rd_t;
   rd_t rd_q[$];

   // Reference model state
   logic [31:0] m_operand, m_az, m_result, m_pend;
   logic        m_irq_en, m_acc, m_done, m_err, m_running;
   int          m_done_cycle;

   wb_mac_regs #(
      .BASE_ADDR   (BASE),
      .MAC_LATENCY (LAT)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .mac_mx_o  (mac_mx_o),
      .mac_my_o  (mac_my_o),
      .mac_az_o  (mac_az_o),
      .mac_res_i (mac_res_i),
      .irq_o     (irq_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   always @(posedge wb_clk_i) cycle <= cycle + 1;

   // Behavioural MAC core with a LAT-deep result pipeline
   logic [31:0] mac_pipe [LAT];
   initial for (int i = 0; i < LAT; i++) mac_pipe[i] = 32'd0;
   always @(posedge wb_clk_i) begin
      mac_pipe[0] <= 32'(mac_mx_o) * 32'(mac_my_o) + mac_az_o;
      for (int i = 1; i < LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
   end
   assign mac_res_i = mac_pipe[LAT-1];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge wb_clk_i) begin
      rd_t e;
      if (!wb_rst_i) begin
         if (wbs_ack_o && !wbs_we_i) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_read_ack: got data 0x%08h, expected no ack", wbs_dat_o);
            end else begin
               e = rd_q.pop_front();
               checkOutput(e.name, wbs_dat_o, e.exp);
            end
         end else if (!wbs_ack_o) begin
            checkOutput("dat_idle_zero", wbs_dat_o, 32'd0);
         end
      end
   end

   function automatic logic [31:0] laneMerge(input logic [31:0] old_val, input logic [31:0] d,
                                             input logic [3:0] sel);
      logic [31:0] mask;
      mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      return (old_val & ~mask) | (d & mask);
   endfunction

   task automatic modelReset();
      m_operand = 0; m_az = 0; m_result = 0; m_pend = 0;
      m_irq_en = 0; m_acc = 0; m_done = 0; m_err = 0; m_running = 0;
      m_done_cycle = 0;
   endtask

   // A run started by an ack in cycle A shows DONE from cycle A+LAT+1.
   task automatic modelAdvance(input int c);
      if (m_running && c >= m_done_cycle) begin
         m_running = 0;
         m_done    = 1;
         m_result  = m_pend;
         if (m_acc) m_az = m_pend;
      end
   endtask

   function automatic logic [31:0] modelRead(input int off);
      case (off)
         0:       return {28'd0, m_acc, 1'b0, m_irq_en, 1'b0};
         1:       return m_operand;
         2:       return m_az;
         3:       return m_result;
         4:       return {29'd0, m_err, m_done, m_running};
         default: return 32'd0;
      endcase
   endfunction

   task automatic modelWrite(input int c, input int off, input logic [3:0] sel, input logic [31:0] d);
      case (off)
         0: if (sel[0]) begin
               m_irq_en = d[1];
`ifdef WB_MAC_ACCUM_EN
               m_acc = d[3];
`endif
               if (d[2]) begin
                  m_done = 0;
                  m_err  = 0;
               end
               if (d[0]) begin
                  if (m_running) m_err = 1;
                  else begin
                     m_running    = 1;
                     m_done       = 0;
                     m_done_cycle = c + LAT + 1;
                     m_pend       = m_operand[15:0] * m_operand[31:16] + m_az;
                  end
               end
            end
         1: if (m_running) m_err = 1; else m_operand = laneMerge(m_operand, d, sel);
         2: if (m_running) m_err = 1; else m_az = laneMerge(m_az, d, sel);
         default: ;
      endcase
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   task automatic waitCycle(input int c);
      while (cycle < c) begin
         @(posedge wb_clk_i);
         #1;
      end
   endtask

   // One classic bus access; must be entered 1ns after a rising edge.
   task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                input logic [31:0] d, input string name, output int ack_cyc);
      bit  hit, seen;
      int  r;
      rd_t e;
      hit = (adr[31:5] == BASE[31:5]);
      r   = cycle + 1;
      if (hit) begin
         modelAdvance(r);
         if (we) modelWrite(r, int'(adr[4:2]), sel, d);
         else begin
            e.name = name;
            e.exp  = modelRead(int'(adr[4:2]));
            rd_q.push_back(e);
         end
      end
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_dat_i = d;    wbs_adr_i = adr;
      seen    = 0;
      ack_cyc = -1;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin
            seen    = 1;
            ack_cyc = cycle;
         end
      end
      if (hit) checkOutput({name, "_ack_cycle"}, ack_cyc, r);
      else     checkOutput({name, "_no_ack"}, {31'd0, seen}, 32'd0);
      @(posedge wb_clk_i);
      #1;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_dat_i = 32'd0;
   endtask

   task automatic wrReg(input int off, input logic [31:0] d, input logic [3:0] sel,
                        input string name, output int ack_cyc);
      applyStimulus(1'b1, BASE + 32'(off * 4), sel, d, name, ack_cyc);
   endtask

   task automatic rdReg(input int off, input string name);
      int ac;
      applyStimulus(1'b0, BASE + 32'(off * 4), 4'hF, 32'd0, name, ac);
   endtask

   task automatic checkAllOutputsZero(input string tag);
      checkOutput({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd0);
      checkOutput({tag, "_dat"}, wbs_dat_o, 32'd0);
      checkOutput({tag, "_irq"}, {31'd0, irq_o}, 32'd0);
      checkOutput({tag, "_mx"}, {16'd0, mac_mx_o}, 32'd0);
      checkOutput({tag, "_my"}, {16'd0, mac_my_o}, 32'd0);
      checkOutput({tag, "_az"}, mac_az_o, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          ac, kind, off, idle;
      logic [31:0] d, adr;
      logic [3:0]  sel;

      modelReset();
      #1 wb_rst_i = 1'b1;
      #1 checkAllOutputsZero("por");
      repeat (2) @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b0;
      rdReg(4, "status_after_reset");

      $display("[TB] basic compute");
      wrReg(1, 32'h0003_0002, 4'hF, "wr_operand", ac);
      wrReg(2, 32'd5, 4'hF, "wr_addend", ac);
      wrReg(0, 32'h1, 4'hF, "wr_start", ac);
      rdReg(4, "status_busy");
      rdReg(4, "status_done");
      rdReg(3, "result_basic");

      $display("[TB] write while busy");
      wrReg(0, 32'h1, 4'hF, "wr_start2", ac);
      wrReg(1, 32'h1234_5678, 4'hF, "wr_operand_busy", ac);
      rdReg(1, "operand_kept");
      rdReg(4, "status_err_done");
      wrReg(0, 32'h4, 4'hF, "wr_clr", ac);
      rdReg(4, "status_cleared");

      $display("[TB] byte lanes and decode");
      wrReg(1, 32'd0, 4'hF, "wr_operand_zero", ac);
      wrReg(1, 32'hFFFF_FFFF, 4'b0011, "wr_operand_low", ac);
      rdReg(1, "operand_lanes");
      applyStimulus(1'b0, BASE + 32'h40, 4'hF, 32'd0, "rd_outside", ac);
      applyStimulus(1'b1, BASE + 32'h44, 4'hF, 32'hDEAD_BEEF, "wr_outside", ac);
      rdReg(1, "operand_after_outside");
      rdReg(5, "rd_hole");
      wrReg(5, 32'hFFFF_FFFF, 4'hF, "wr_hole", ac);
      rdReg(5, "rd_hole_again");

      $display("[TB] interrupt");
      wrReg(0, 32'h2, 4'hF, "wr_irq_en", ac);
      rdReg(0, "ctrl_irq_en");
      wrReg(0, 32'h3, 4'hF, "wr_start_irq", ac);
      waitCycle(ac + LAT + 1);
      @(negedge wb_clk_i);
      checkOutput("irq_low_on_done_cycle", {31'd0, irq_o}, 32'd0);
      tick(1);
      @(negedge wb_clk_i);
      checkOutput("irq_high_after_done", {31'd0, irq_o}, 32'd1);
      tick(1);
      rdReg(4, "status_irq_done");
      wrReg(0, 32'h6, 4'hF, "wr_clr_irq", ac);
      @(negedge wb_clk_i);
      checkOutput("irq_still_high", {31'd0, irq_o}, 32'd1);
      tick(1);
      @(negedge wb_clk_i);
      checkOutput("irq_low_after_clr", {31'd0, irq_o}, 32'd0);
      tick(1);

`ifdef WB_MAC_ACCUM_EN
      $display("[TB] accumulate");
      wrReg(1, 32'h0003_0002, 4'hF, "acc_operand", ac);
      wrReg(2, 32'd0, 4'hF, "acc_addend", ac);
      wrReg(0, 32'h8, 4'hF, "acc_enable", ac);
      rdReg(0, "ctrl_acc");
      for (int k = 0; k < 3; k++) begin
         wrReg(0, 32'h9, 4'hF, "acc_start", ac);
         tick(LAT + 1);
         rdReg(3, "acc_result");
      end
      rdReg(2, "acc_addend_fed_back");
      wrReg(0, 32'h4, 4'hF, "acc_disable", ac);
`endif

      $display("[TB] randomized traffic");
      for (int t = 0; t < 300; t++) begin
         idle = int'($urandom_range(0, 3));
         tick(idle);
         kind = int'($urandom_range(0, 9));
         d    = $urandom;
         sel  = 4'($urandom_range(1, 15));
         case (kind)
            0, 1: begin
               d = {28'd0, m_acc, 3'($urandom_range(0, 7)) | 3'b001};
               wrReg(0, d, 4'hF, "rnd_start", ac);
            end
            2: begin
               wrReg(1, d, sel, "rnd_operand", ac);
               checkOutput("rnd_mac_mx", {16'd0, mac_mx_o}, {16'd0, m_operand[15:0]});
               checkOutput("rnd_mac_my", {16'd0, mac_my_o}, {16'd0, m_operand[31:16]});
            end
            3: begin
               wrReg(2, d, sel, "rnd_addend", ac);
               checkOutput("rnd_mac_az", mac_az_o, m_az);
            end
            4: begin
               d = {28'd0, m_acc, 3'($urandom_range(0, 7))};
               wrReg(0, d, sel, "rnd_ctrl", ac);
            end
            5: begin
               off = int'($urandom_range(0, 7));
               adr = (BASE ^ (32'h20 << $urandom_range(0, 26))) | 32'(off * 4);
               applyStimulus(1'($urandom_range(0, 1)), adr, 4'hF, d, "rnd_outside", ac);
            end
            6: wrReg(int'($urandom_range(3, 7)), d, 4'hF, "rnd_ro_write", ac);
            default: rdReg(int'($urandom_range(0, 7)), "rnd_read");
         endcase
      end
      tick(LAT + 3);
      rdReg(4, "rnd_final_status");
      rdReg(3, "rnd_final_result");

      $display("[TB] reset during compute");
      wrReg(0, 32'h4, 4'hF, "pre_rst_clr", ac);
      wrReg(1, 32'h0005_0007, 4'hF, "pre_rst_operand", ac);
      wrReg(2, 32'd9, 4'hF, "pre_rst_addend", ac);
      wrReg(0, 32'h3, 4'hF, "pre_rst_start", ac);
      waitCycle(ac + LAT + 2);
      @(negedge wb_clk_i);
      checkOutput("pre_rst_irq_high", {31'd0, irq_o}, 32'd1);
      tick(1);
      wrReg(0, 32'h3, 4'hF, "pre_rst_restart", ac);
      #2 wb_rst_i = 1'b1;
      #1 checkAllOutputsZero("midrun_rst");
      modelReset();
      @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b0;
      rdReg(4, "status_post_rst");
      rdReg(0, "ctrl_post_rst");
      rdReg(1, "operand_post_rst");
      rdReg(3, "result_post_rst");

      tick(3);
      checkOutput("scoreboard_drained", rd_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
